// File: rtl/detector_stream_ctrl_pkg.sv
// Shared definitions for the detector stream controller.
//   state_t    : controller FSM states, binary encoded
//   HIT_IDX_W  : width of bit indices (bit counter and last_hit)
package detector_stream_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_SHIFT = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int HIT_IDX_W = 5;

endpackage

// File: rtl/detector_stream_ctrl_stream_shifter.sv
// Serialiser for the detector stream controller: holds the word, shifts it
// out LSB first and tracks which bit index is currently presented.
//   clock, reset : system clock, async active-high reset
//   load         : capture data_in and restart the bit count
//   shift        : advance one bit (shift right, count up)
//   data_in      : word to serialise
//   bit_out      : current LSB of the shift register
//   bit_idx      : index of the bit currently on bit_out
//   last_bit     : bit_idx is the final bit of the word
module stream_shifter
  import detector_stream_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 shift,
  input  logic [WIDTH-1:0]     data_in,
  output logic                 bit_out,
  output logic [HIT_IDX_W-1:0] bit_idx,
  output logic                 last_bit
);

  logic [WIDTH-1:0]     shreg;
  logic [HIT_IDX_W-1:0] bit_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      shreg   <= data_in;
      bit_cnt <= '0;
    end else if (shift) begin
      shreg   <= shreg >> 1;
      bit_cnt <= bit_cnt + HIT_IDX_W'(1);
    end
  end

  assign bit_out  = shreg[0];
  assign bit_idx  = bit_cnt;
  assign last_bit = (bit_cnt == HIT_IDX_W'(WIDTH - 1));

endmodule

// File: rtl/detector_stream_ctrl.sv
// Sequencer that clears the four-in-a-row detector, streams a word into it
// LSB first and collects hit statistics from its registered z output.
//   clock, reset     : system clock, async active-high reset
//   start, data_in   : run request and word, accepted only when ready
//   abort            : cancel a run in progress (wins over start in IDLE)
//   det_z            : registered detector output
//   ready / busy     : idle indication and its complement
//   det_clear        : one-cycle detector clear before the first bit
//   det_step, det_w  : detector step enable and serial bit
//   done             : one-cycle pulse after a complete run
//   match_count      : saturating count of z=1 samples in the run
//   last_hit         : bit index whose step produced the latest hit
//   hit_any          : at least one hit in the run
//
// state   | meaning
// S_IDLE  | waiting for start, results of the previous run held
// S_CLEAR | detector clear pulse
// S_SHIFT | one bit stepped into the detector per cycle
// S_DRAIN | sample z produced by the final step
// S_DONE  | done pulse, results final
module detector_stream_ctrl
  import detector_stream_ctrl_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CW    = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 det_z,
  output logic                 ready,
  output logic                 busy,
  output logic                 det_clear,
  output logic                 det_step,
  output logic                 det_w,
  output logic                 done,
  output logic [CW-1:0]        match_count,
  output logic [HIT_IDX_W-1:0] last_hit,
  output logic                 hit_any
);

  state_t               state_q, state_d;
  logic                 abort_run;
  logic                 load;
  logic                 bit_out;
  logic                 last_bit;
  logic [HIT_IDX_W-1:0] bit_idx;
  logic                 z_valid;
  logic [HIT_IDX_W-1:0] z_idx;

  stream_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .shift    (det_step),
    .data_in  (data_in),
    .bit_out  (bit_out),
    .bit_idx  (bit_idx),
    .last_bit (last_bit)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  assign abort_run = abort && (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    if (abort_run) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start && !abort) state_d = S_CLEAR;
        S_CLEAR: state_d = S_SHIFT;
        S_SHIFT: if (last_bit) state_d = S_DRAIN;
        S_DRAIN: state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Abort suppresses every run-phase output in the cycle it is seen.
  always_comb begin
    ready     = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    load      = (state_q == S_IDLE) && start && !abort;
    det_clear = (state_q == S_CLEAR) && !abort_run;
    det_step  = (state_q == S_SHIFT) && !abort_run;
    det_w     = det_step && bit_out;
    done      = (state_q == S_DONE) && !abort_run;
  end

  // z lags det_step by one cycle; the step's bit index travels with it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      z_valid     <= 1'b0;
      z_idx       <= '0;
      match_count <= '0;
      last_hit    <= '0;
      hit_any     <= 1'b0;
    end else begin
      z_valid <= det_step;
      z_idx   <= bit_idx;
      if (load) begin
        match_count <= '0;
        last_hit    <= '0;
        hit_any     <= 1'b0;
      end else if (z_valid && det_z && !abort_run) begin
        if (match_count != {CW{1'b1}}) match_count <= match_count + CW'(1);
        last_hit <= z_idx;
        hit_any  <= 1'b1;
      end
    end
  end

endmodule
